// File: rtl/tc_add_reduce_pkg.sv
// Shared types for tc_add_reduce: state encoding, fflags bit positions, tag payload.
// `DEPTH_WARP normally comes from define.v; a fallback width is provided here.
`timescale 1ns/1ps
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

package tc_add_reduce_pkg;

  localparam int unsigned RM_W     = 3;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned FFLAGS_W = 5;
  localparam int unsigned WARP_W   = `DEPTH_WARP;

  // fflags bit positions
  localparam int unsigned FF_NV = 4;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_NX = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Writeback tag carried alongside each job
  typedef struct packed {
    logic [REG_W-1:0]  reg_idxw;
    logic [WARP_W-1:0] warpid;
  } tag_t;

  function automatic int unsigned calc_w(input int unsigned expwidth, input int unsigned precision);
    return expwidth + precision;
  endfunction

endpackage

// File: rtl/tc_add_reduce_buf.sv
// tc_reduce_buf: shift-style operand FIFO with parallel load, pop-2 and push-1.
// A push in the same cycle as a pop-2 lands right after the surviving entries.
`timescale 1ns/1ps
module tc_reduce_buf #(
  parameter  int unsigned W     = 32,
  parameter  int unsigned DEPTH = 5,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [DEPTH*W-1:0] load_data,
  input  logic               pop2,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  output logic [W-1:0]       head0,
  output logic [W-1:0]       head1,
  output logic [CW-1:0]      count
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [W-1:0]  ent_q [DEPTH];
  logic [W-1:0]  ent_n [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] base;

  // Next buffer contents: clear, load, or shift-down-by-2 followed by tail push
  always_comb begin
    ent_n = ent_q;
    cnt_n = cnt_q;
    base  = cnt_q;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_n[i] = '0;
      cnt_n = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_n[i] = load_data[i*W +: W];
      cnt_n = CW'(DEPTH);
    end else begin
      if (pop2) begin
        for (int unsigned i = 0; i < DEPTH - 2; i++) ent_n[i] = ent_q[i+2];
        ent_n[DEPTH-2] = '0;
        ent_n[DEPTH-1] = '0;
        base = cnt_q - CW'(2);
      end
      if (push) ent_n[IW'(base)] = push_data;
      cnt_n = base + CW'(push);
    end
  end

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_n;
      cnt_q <= cnt_n;
    end
  end

  assign head0 = ent_q[0];
  assign head1 = ent_q[1];
  assign count = cnt_q;

endmodule

// File: rtl/tc_add_reduce.sv
// tc_add_reduce: reduces NUM_OPS values plus accumulator C through an external
// pipelined FP adder, pairing operands in FIFO order.
// Optional tag check enabled by defining TC_ADD_REDUCE_TAGCHK_EN.
`timescale 1ns/1ps
module tc_add_reduce
  import tc_add_reduce_pkg::*;
#(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned NUM_OPS   = 4,
  parameter int unsigned PIPE_LAT  = 2,
  localparam int unsigned W        = EXPWIDTH + PRECISION
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [NUM_OPS*W-1:0]   job_data_i,
  input  logic [W-1:0]           job_c_i,
  input  logic [2:0]             job_rm_i,
  input  logic [7:0]             job_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0] job_warpid_i,
  output logic                   add_valid_o,
  input  logic                   add_ready_i,
  output logic [W-1:0]           add_a_o,
  output logic [W-1:0]           add_b_o,
  output logic [2:0]             add_rm_o,
  output logic [W-1:0]           add_ctrl_c_o,
  output logic [2:0]             add_ctrl_rm_o,
  output logic [7:0]             add_ctrl_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0] add_ctrl_warpid_o,
  input  logic                   add_valid_i,
  output logic                   add_ready_o,
  input  logic [W-1:0]           add_result_i,
  input  logic [4:0]             add_fflags_i,
  input  logic [7:0]             add_ctrl_reg_idxw_i,
  input  logic [`DEPTH_WARP-1:0] add_ctrl_warpid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [W-1:0]           out_result_o,
  output logic [4:0]             out_fflags_o,
  output logic [7:0]             out_reg_idxw_o,
  output logic [`DEPTH_WARP-1:0] out_warpid_o,
  output logic                   err_o
);

  localparam int unsigned DEPTH = NUM_OPS + 1;
  localparam int unsigned BCW   = $clog2(DEPTH + 1);
  localparam int unsigned CW    = $clog2(NUM_OPS + 1);

  // Elaboration-time sanity of the configuration
  if (NUM_OPS < 2 || PIPE_LAT < 1 || calc_w(EXPWIDTH, PRECISION) != W) begin : g_bad_cfg
    $error("tc_add_reduce: NUM_OPS must be >= 2 and PIPE_LAT >= 1");
  end

  state_e               state_q, state_n;
  logic [CW-1:0]        issued_q, returned_q;
  logic [RM_W-1:0]      rm_q;
  tag_t                 tag_q;
  logic [FFLAGS_W-1:0]  fflags_q;

  logic [W-1:0]   head0, head1;
  logic [BCW-1:0] count;
  logic           buf_clear, buf_load, fire, ret;

  tc_reduce_buf #(.W(W), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (buf_clear),
    .load      (buf_load),
    .load_data ({job_data_i, job_c_i}),
    .pop2      (fire),
    .push      (ret),
    .push_data (add_result_i),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  // Next state, handshakes and output decode from registered state
  always_comb begin
    state_n             = state_q;
    job_ready_o         = 1'b0;
    add_valid_o         = 1'b0;
    add_ready_o         = 1'b0;
    add_a_o             = '0;
    add_b_o             = '0;
    out_valid_o         = 1'b0;
    out_result_o        = '0;
    buf_clear           = 1'b0;
    buf_load            = 1'b0;
    fire                = 1'b0;
    ret                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) begin
          buf_load = 1'b1;
          state_n  = REDUCE;
        end
      end
      REDUCE: begin
        add_ready_o = 1'b1;
        add_valid_o = (count >= BCW'(2)) && (issued_q < CW'(NUM_OPS));
        add_a_o     = head0;
        add_b_o     = head1;
        fire        = add_valid_o && add_ready_i;
        ret         = add_valid_i;
        if (ret && returned_q == CW'(NUM_OPS - 1)) state_n = DONE;
      end
      DONE: begin
        out_valid_o  = 1'b1;
        out_result_o = head0;
        if (out_ready_i) begin
          buf_clear = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign add_rm_o            = rm_q;
  assign add_ctrl_c_o        = '0;
  assign add_ctrl_rm_o       = rm_q;
  assign add_ctrl_reg_idxw_o = tag_q.reg_idxw;
  assign add_ctrl_warpid_o   = tag_q.warpid;
  assign out_fflags_o        = fflags_q;
  assign out_reg_idxw_o      = tag_q.reg_idxw;
  assign out_warpid_o        = tag_q.warpid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Job context, issue/return counters and fflags accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q   <= '0;
      returned_q <= '0;
      rm_q       <= '0;
      tag_q      <= '0;
      fflags_q   <= '0;
    end else if (buf_load) begin
      issued_q       <= '0;
      returned_q     <= '0;
      rm_q           <= job_rm_i;
      tag_q.reg_idxw <= job_reg_idxw_i;
      tag_q.warpid   <= job_warpid_i;
      fflags_q       <= '0;
    end else begin
      if (fire) issued_q <= issued_q + CW'(1);
      if (ret) begin
        returned_q <= returned_q + CW'(1);
        fflags_q   <= fflags_q | add_fflags_i;
      end
    end
  end

`ifdef TC_ADD_REDUCE_TAGCHK_EN
  logic err_q;

  // Sticky flag on any returned tag differing from the job's tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (ret && (add_ctrl_reg_idxw_i != tag_q.reg_idxw || add_ctrl_warpid_i != tag_q.warpid))
      err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  logic unused_tags;
  assign unused_tags = ^{add_ctrl_reg_idxw_i, add_ctrl_warpid_i};
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_tc_add_reduce.sv
// Directed bench for tc_add_reduce with a small behavioural add pipe
// (latency LAT, exact for small integer and inf/NaN operands).
`timescale 1ns/1ps
`ifndef DEPTH_WARP
`define DEPTH_WARP 4
`endif

module tb_tc_add_reduce;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned WD  = `DEPTH_WARP;

`ifdef TC_ADD_REDUCE_TAGCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  localparam logic [31:0] F0 = 32'h00000000, F1 = 32'h3F800000, F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000, F4 = 32'h40800000, F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000, F7 = 32'h40E00000, F8 = 32'h41000000;
  localparam logic [31:0] PINF = 32'h7F800000, NINF = 32'hFF800000, QNAN = 32'h7FC00000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid_i;
  logic          job_ready_o;
  logic [N*W-1:0] job_data_i;
  logic [W-1:0]  job_c_i;
  logic [2:0]    job_rm_i;
  logic [7:0]    job_reg_idxw_i;
  logic [WD-1:0] job_warpid_i;
  logic          add_valid_o;
  logic          add_ready_i;
  logic [W-1:0]  add_a_o, add_b_o;
  logic [2:0]    add_rm_o;
  logic [W-1:0]  add_ctrl_c_o;
  logic [2:0]    add_ctrl_rm_o;
  logic [7:0]    add_ctrl_reg_idxw_o;
  logic [WD-1:0] add_ctrl_warpid_o;
  logic          add_valid_i;
  logic          add_ready_o;
  logic [W-1:0]  add_result_i;
  logic [4:0]    add_fflags_i;
  logic [7:0]    add_ctrl_reg_idxw_i;
  logic [WD-1:0] add_ctrl_warpid_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  out_result_o;
  logic [4:0]    out_fflags_o;
  logic [7:0]    out_reg_idxw_o;
  logic [WD-1:0] out_warpid_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tc_add_reduce #(.EXPWIDTH(8), .PRECISION(24), .NUM_OPS(N), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_data_i(job_data_i),
    .job_c_i(job_c_i), .job_rm_i(job_rm_i), .job_reg_idxw_i(job_reg_idxw_i),
    .job_warpid_i(job_warpid_i),
    .add_valid_o(add_valid_o), .add_ready_i(add_ready_i), .add_a_o(add_a_o), .add_b_o(add_b_o),
    .add_rm_o(add_rm_o), .add_ctrl_c_o(add_ctrl_c_o), .add_ctrl_rm_o(add_ctrl_rm_o),
    .add_ctrl_reg_idxw_o(add_ctrl_reg_idxw_o), .add_ctrl_warpid_o(add_ctrl_warpid_o),
    .add_valid_i(add_valid_i), .add_ready_o(add_ready_o), .add_result_i(add_result_i),
    .add_fflags_i(add_fflags_i), .add_ctrl_reg_idxw_i(add_ctrl_reg_idxw_i),
    .add_ctrl_warpid_i(add_ctrl_warpid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_result_o(out_result_o),
    .out_fflags_o(out_fflags_o), .out_reg_idxw_o(out_reg_idxw_o), .out_warpid_o(out_warpid_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference FP add (small non-negative integers, inf, NaN) ----------------
  function automatic int unsigned f2i(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m) >> (23 - e);
  endfunction

  function automatic logic [31:0] i2f(input int unsigned v);
    int p;
    logic [31:0] sh;
    if (v == 0) return 32'd0;
    p = 0;
    for (int k = 0; k < 24; k++) if (v[k]) p = k;
    sh = v << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (&f[30:23]) && (|f[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (&f[30:23]) && (f[22:0] == 23'd0);
  endfunction

  // returns {fflags, result}
  function automatic logic [36:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return {5'd0, QNAN};
    if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return {5'b10000, QNAN};
    if (is_inf(a)) return {5'd0, a};
    if (is_inf(b)) return {5'd0, b};
    return {5'd0, i2f(f2i(a) + f2i(b))};
  endfunction

  // ---------------- add pipe model ----------------
  logic          pv   [LAT];
  logic [31:0]   pres [LAT];
  logic [4:0]    pfl  [LAT];
  logic [7:0]    preg [LAT];
  logic [WD-1:0] pw   [LAT];
  int            issue_cnt;
  logic          corrupt_req = 1'b0;
  logic          corrupt_done;
  logic          pfire;

  assign pfire = add_valid_o && add_ready_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0; pres[i] <= '0; pfl[i] <= '0; preg[i] <= '0; pw[i] <= '0;
      end
      issue_cnt    <= 0;
      corrupt_done <= 1'b0;
    end else begin
      pv[0]               <= pfire;
      {pfl[0], pres[0]}   <= fadd(add_a_o, add_b_o);
      preg[0]             <= add_ctrl_reg_idxw_o;
      pw[0]               <= (pfire && corrupt_req && !corrupt_done) ? (add_ctrl_warpid_o ^ WD'(1))
                                                                   : add_ctrl_warpid_o;
      if (pfire && corrupt_req) corrupt_done <= 1'b1;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1]; pres[i] <= pres[i-1]; pfl[i] <= pfl[i-1];
        preg[i] <= preg[i-1]; pw[i] <= pw[i-1];
      end
      if (pfire) issue_cnt <= issue_cnt + 1;
    end
  end

  assign add_valid_i         = pv[LAT-1];
  assign add_result_i        = pres[LAT-1];
  assign add_fflags_i        = pfl[LAT-1];
  assign add_ctrl_reg_idxw_i = preg[LAT-1];
  assign add_ctrl_warpid_i   = pw[LAT-1];

  // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
  task automatic send_job(input logic [31:0] c, input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3, input logic [2:0] rm,
                          input logic [7:0] ridx, input logic [WD-1:0] wid, output int acc_cyc);
    logic ok;
    job_c_i = c; job_data_i = {v3, v2, v1, v0};
    job_rm_i = rm; job_reg_idxw_i = ridx; job_warpid_i = wid;
    job_valid_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (job_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL job_accept: job_ready_o never high, required 1"); end
    acc_cyc = cyc;
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  task automatic wait_out(input int budget, output logic got);
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (out_valid_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL out_timeout: out_valid_o=0 after %0d cycles, required 1", budget); end
  endtask

  task automatic wait_issues(input int target);
    logic ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (issue_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL issue_timeout: issue_cnt=%0d, required %0d", issue_cnt, target); end
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; job_valid_i = 1'b0; job_data_i = '0; job_c_i = '0; job_rm_i = '0;
    job_reg_idxw_i = '0; job_warpid_i = '0; add_ready_i = 1'b1; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b, required 1", job_ready_o); end
    n_checks++; if (add_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_add_valid: got %b, required 0", add_valid_o); end
    n_checks++; if (add_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_add_ready: got %b, required 0", add_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_o); end
    n_checks++; if ({out_result_o, out_fflags_o, add_a_o, add_b_o} !== '0) begin n_fail++; $display("FAIL reset_data: got result %h fflags %h a %h b %h, required all 0", out_result_o, out_fflags_o, add_a_o, add_b_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_sum();
    int acc, base;
    logic got;
    base = issue_cnt;
    send_job(F0, F1, F2, F3, F4, 3'd0, 8'h15, WD'(3), acc);
    wait_out(20, got);
    n_checks++; if (cyc - acc > 12) begin n_fail++; $display("FAIL basic_latency: %0d cycles after accept, required <= 12", cyc - acc); end
    n_checks++; if (out_result_o !== 32'h41200000) begin n_fail++; $display("FAIL basic_result: got %h, required 41200000", out_result_o); end
    n_checks++; if (out_fflags_o !== 5'd0) begin n_fail++; $display("FAIL basic_fflags: got %h, required 00", out_fflags_o); end
    n_checks++; if (issue_cnt - base !== 4) begin n_fail++; $display("FAIL basic_issues: got %0d, required 4", issue_cnt - base); end
    n_checks++; if (out_reg_idxw_o !== 8'h15 || out_warpid_o !== WD'(3)) begin n_fail++; $display("FAIL basic_tags: got %h/%h, required 15/%h", out_reg_idxw_o, out_warpid_o, WD'(3)); end
    handshake();
  endtask

  task automatic test_stall();
    int acc, base;
    logic got, held;
    logic [31:0] a0, b0;
    base = issue_cnt;
    send_job(F0, F1, F2, F3, F4, 3'd2, 8'h21, WD'(1), acc);
    wait_issues(base + 1);
    add_ready_i = 1'b0;
    a0 = add_a_o; b0 = add_b_o;
    held = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (add_valid_o !== 1'b1 || add_a_o !== a0 || add_b_o !== b0 || add_rm_o !== 3'd2 ||
          add_ctrl_rm_o !== 3'd2 || add_ctrl_c_o !== '0 || add_ctrl_warpid_o !== WD'(1)) held = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL stall_hold: a=%h b=%h valid=%b rm=%h, required a=%h b=%h valid=1 rm=2", add_a_o, add_b_o, add_valid_o, add_rm_o, a0, b0); end
    n_checks++; if ({a0, b0} !== {F2, F3}) begin n_fail++; $display("FAIL stall_pair: got %h/%h, required %h/%h", a0, b0, F2, F3); end
    n_checks++; if (issue_cnt - base !== 1) begin n_fail++; $display("FAIL stall_issues: got %0d, required 1", issue_cnt - base); end
    add_ready_i = 1'b1;
    wait_out(30, got);
    n_checks++; if (out_result_o !== 32'h41200000) begin n_fail++; $display("FAIL stall_result: got %h, required 41200000", out_result_o); end
    handshake();
  endtask

  task automatic test_nan();
    int acc;
    logic got;
    send_job(PINF, NINF, F1, F1, F1, 3'd0, 8'h02, WD'(2), acc);
    wait_out(30, got);
    n_checks++; if (out_result_o !== QNAN) begin n_fail++; $display("FAIL nan_result: got %h, required 7fc00000", out_result_o); end
    n_checks++; if (out_fflags_o !== 5'h10) begin n_fail++; $display("FAIL nan_fflags: got %h, required 10", out_fflags_o); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int acc, acc2, hs;
    logic got, held;
    send_job(F0, F1, F2, F3, F4, 3'd0, 8'h33, WD'(0), acc);
    wait_out(30, got);
    held = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid_o !== 1'b1 || out_result_o !== 32'h41200000 || job_ready_o !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL out_hold: valid=%b result=%h job_ready=%b, required 1/41200000/0", out_valid_o, out_result_o, job_ready_o); end
    hs = cyc;
    handshake();
    n_checks++; if (job_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_hs: job_ready=%b out_valid=%b, required 1/0", job_ready_o, out_valid_o); end
    send_job(F1, F5, F6, F7, F8, 3'd1, 8'h44, WD'(1), acc2);
    n_checks++; if (acc2 !== hs + 1) begin n_fail++; $display("FAIL b2b_accept: accepted at cycle %0d, required %0d", acc2, hs + 1); end
    wait_out(30, got);
    n_checks++; if (out_result_o !== 32'h41D80000) begin n_fail++; $display("FAIL b2b_result: got %h, required 41d80000", out_result_o); end
    n_checks++; if (out_reg_idxw_o !== 8'h44) begin n_fail++; $display("FAIL b2b_tag: got %h, required 44", out_reg_idxw_o); end
    handshake();
  endtask

  task automatic test_tagchk();
    int acc;
    logic got;
    corrupt_req = 1'b1;
    send_job(F0, F1, F2, F3, F4, 3'd0, 8'h55, WD'(2), acc);
    wait_out(30, got);
    n_checks++; if (out_result_o !== 32'h41200000) begin n_fail++; $display("FAIL tag_result: got %h, required 41200000", out_result_o); end
    n_checks++; if (err_o !== EXP_ERR) begin n_fail++; $display("FAIL tag_err: got %b, required %b", err_o, EXP_ERR); end
    handshake();
    send_job(F0, F1, F1, F1, F1, 3'd0, 8'h56, WD'(2), acc);
    wait_out(30, got);
    n_checks++; if (out_result_o !== F4) begin n_fail++; $display("FAIL tag_result2: got %h, required %h", out_result_o, F4); end
    n_checks++; if (err_o !== EXP_ERR) begin n_fail++; $display("FAIL tag_sticky: got %b, required %b", err_o, EXP_ERR); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int acc;
    logic got;
    send_job(F0, F1, F2, F3, F4, 3'd0, 8'h66, WD'(1), acc);
    wait_issues(2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (job_ready_o !== 1'b1 || add_valid_o !== 1'b0 || out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: job_ready=%b add_valid=%b out_valid=%b, required 1/0/0", job_ready_o, add_valid_o, out_valid_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b, required 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_job(F0, F1, F2, F3, F4, 3'd0, 8'h67, WD'(1), acc);
    wait_out(30, got);
    n_checks++; if (out_result_o !== 32'h41200000) begin n_fail++; $display("FAIL midrst_result: got %h, required 41200000", out_result_o); end
    n_checks++; if (out_fflags_o !== 5'd0) begin n_fail++; $display("FAIL midrst_fflags: got %h, required 00", out_fflags_o); end
    handshake();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_sum();
    test_stall();
    test_nan();
    test_back_to_back();
    test_tagchk();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
